inst_fetch_buffer: RTL and testbench

INST_FETCH_BUFFER -- requirements
Module: inst_fetch_buffer

---
 rtl/inst_fetch_buffer.sv | 131 +++++++++++++
 tb/tb_inst_fetch_buffer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_buffer.sv
// Circular instruction fetch buffer between I-cache and decode: up to 2 pushes and 2 pops per cycle.
// Optional macro INST_FETCH_BUFFER_BYPASS_EN lets an empty buffer show the incoming fetch packet combinationally.
module inst_fetch_buffer #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid0,
    input  logic                     in_valid1,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_inst0,
    input  logic [31:0]              in_inst1,
    input  logic                     in_tlb_refill,
    input  logic                     in_tlb_invalid,
    output logic                     full,
    output logic                     out_valid0,
    output logic                     out_valid1,
    output logic [31:0]              out_pc0,
    output logic [31:0]              out_pc1,
    output logic [31:0]              out_inst0,
    output logic [31:0]              out_inst1,
    output logic                     out_tlb_refill0,
    output logic                     out_tlb_refill1,
    output logic                     out_tlb_invalid0,
    output logic                     out_tlb_invalid1,
    input  logic [1:0]               pop_cnt,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_AT = (AW+1)'(DEPTH - 1);

    logic [31:0] pcMem      [DEPTH];
    logic [31:0] instMem    [DEPTH];
    logic        refillMem  [DEPTH];
    logic        invalidMem [DEPTH];

    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] headNext, tailNext;
    logic          slot1Ok;
    logic [1:0]    pushN;

    assign full     = count_q >= FULL_AT;
    assign count    = count_q;
    assign headNext = head_q + AW'(1);
    assign tailNext = tail_q + AW'(1);

    // A fetch exception on slot 0 kills slot 1 even if the cache marked it valid.
    always_comb begin
        slot1Ok = in_valid1 && !in_tlb_refill && !in_tlb_invalid;
        pushN   = 2'd0;
        if (in_valid0 && !full) begin
            pushN = slot1Ok ? 2'd2 : 2'd1;
        end
        head_d  = head_q + AW'(pop_cnt);
        tail_d  = tail_q + AW'(pushN);
        count_d = count_q + (AW+1)'(pushN) - (AW+1)'(pop_cnt);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Bypassed entries are still written at tail; advancing head past them discards them.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            if (pushN != 2'd0) begin
                pcMem[tail_q]      <= in_pc;
                instMem[tail_q]    <= in_inst0;
                refillMem[tail_q]  <= in_tlb_refill;
                invalidMem[tail_q] <= in_tlb_invalid;
            end
            if (pushN == 2'd2) begin
                pcMem[tailNext]      <= in_pc + 32'd4;
                instMem[tailNext]    <= in_inst1;
                refillMem[tailNext]  <= 1'b0;
                invalidMem[tailNext] <= 1'b0;
            end
        end
    end

    always_comb begin
        out_valid0       = count_q != '0;
        out_valid1       = count_q >= (AW+1)'(2);
        out_pc0          = pcMem[head_q];
        out_pc1          = pcMem[headNext];
        out_inst0        = instMem[head_q];
        out_inst1        = instMem[headNext];
        out_tlb_refill0  = refillMem[head_q];
        out_tlb_refill1  = refillMem[headNext];
        out_tlb_invalid0 = invalidMem[head_q];
        out_tlb_invalid1 = invalidMem[headNext];
`ifdef INST_FETCH_BUFFER_BYPASS_EN
        if (count_q == '0 && !flush) begin
            out_valid0       = in_valid0;
            out_valid1       = in_valid0 && slot1Ok;
            out_pc0          = in_pc;
            out_pc1          = in_pc + 32'd4;
            out_inst0        = in_inst0;
            out_inst1        = in_inst1;
            out_tlb_refill0  = in_tlb_refill;
            out_tlb_refill1  = 1'b0;
            out_tlb_invalid0 = in_tlb_invalid;
            out_tlb_invalid1 = 1'b0;
        end
`endif
    end

    logic [AW:0] visibleCount;
`ifdef INST_FETCH_BUFFER_BYPASS_EN
    assign visibleCount = (count_q == '0) ? (AW+1)'(pushN) : count_q;
`else
    assign visibleCount = count_q;
`endif

    popLegal: assert property (@(posedge clk) disable iff (rst || flush)
        (pop_cnt != 2'd3) && ((AW+1)'(pop_cnt) <= visibleCount));
    slot1NeedsSlot0: assert property (@(posedge clk) disable iff (rst)
        in_valid1 |-> in_valid0);

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Self-checking bench for inst_fetch_buffer: queue reference model compared every cycle plus directed literal checks.
module tb_inst_fetch_buffer;

    localparam int DEPTH = 16;
`ifdef INST_FETCH_BUFFER_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk, rst, flush, in_valid0, in_valid1, in_tlb_refill, in_tlb_invalid;
    logic [31:0] in_pc, in_inst0, in_inst1;
    logic [1:0]  pop_cnt;
    logic        full, out_valid0, out_valid1;
    logic [31:0] out_pc0, out_pc1, out_inst0, out_inst1;
    logic        out_tlb_refill0, out_tlb_refill1, out_tlb_invalid0, out_tlb_invalid1;
    logic [4:0]  count;

    inst_fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid0(in_valid0), .in_valid1(in_valid1), .in_pc(in_pc),
        .in_inst0(in_inst0), .in_inst1(in_inst1),
        .in_tlb_refill(in_tlb_refill), .in_tlb_invalid(in_tlb_invalid),
        .full(full), .out_valid0(out_valid0), .out_valid1(out_valid1),
        .out_pc0(out_pc0), .out_pc1(out_pc1), .out_inst0(out_inst0), .out_inst1(out_inst1),
        .out_tlb_refill0(out_tlb_refill0), .out_tlb_refill1(out_tlb_refill1),
        .out_tlb_invalid0(out_tlb_invalid0), .out_tlb_invalid1(out_tlb_invalid1),
        .pop_cnt(pop_cnt), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        refill;
        logic        invalid;
    } entry_t;

    entry_t modelQ[$];
    bit     started = 1'b0;
    int     checkCount = 0;
    int     passCount = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    // Reference: an ordered queue; pushes append, pops take from the front.
    always @(posedge clk) begin
        if (rst) begin
            modelQ.delete();
            started = 1'b1;
        end else if (flush) begin
            modelQ.delete();
        end else begin
            if (in_valid0 && (DEPTH - modelQ.size()) >= 2) begin
                modelQ.push_back('{in_pc, in_inst0, in_tlb_refill, in_tlb_invalid});
                if (in_valid1 && !in_tlb_refill && !in_tlb_invalid)
                    modelQ.push_back('{in_pc + 32'd4, in_inst1, 1'b0, 1'b0});
            end
            for (int i = 0; i < int'(pop_cnt); i++)
                if (modelQ.size() > 0) void'(modelQ.pop_front());
        end
    end

    always @(negedge clk) begin
        entry_t e0, e1;
        bit     v0, v1;
        if (started) begin
            if (BYPASS && modelQ.size() == 0 && !flush) begin
                v0 = in_valid0;
                v1 = in_valid0 && in_valid1 && !in_tlb_refill && !in_tlb_invalid;
                e0 = '{in_pc, in_inst0, in_tlb_refill, in_tlb_invalid};
                e1 = '{in_pc + 32'd4, in_inst1, 1'b0, 1'b0};
            end else begin
                v0 = modelQ.size() >= 1;
                v1 = modelQ.size() >= 2;
                e0 = v0 ? modelQ[0] : '{32'd0, 32'd0, 1'b0, 1'b0};
                e1 = v1 ? modelQ[1] : '{32'd0, 32'd0, 1'b0, 1'b0};
            end
            checkOutput("model.count", 32'(count), 32'(modelQ.size()));
            checkOutput("model.full", 32'(full), 32'((DEPTH - modelQ.size()) < 2));
            checkOutput("model.valid0", 32'(out_valid0), 32'(v0));
            checkOutput("model.valid1", 32'(out_valid1), 32'(v1));
            if (v0) begin
                checkOutput("model.pc0", out_pc0, e0.pc);
                checkOutput("model.inst0", out_inst0, e0.inst);
                checkOutput("model.refill0", 32'(out_tlb_refill0), 32'(e0.refill));
                checkOutput("model.invalid0", 32'(out_tlb_invalid0), 32'(e0.invalid));
            end
            if (v1) begin
                checkOutput("model.pc1", out_pc1, e1.pc);
                checkOutput("model.inst1", out_inst1, e1.inst);
                checkOutput("model.refill1", 32'(out_tlb_refill1), 32'(e1.refill));
                checkOutput("model.invalid1", 32'(out_tlb_invalid1), 32'(e1.invalid));
            end
        end
    end

    task automatic setIdle();
        flush = 1'b0; in_valid0 = 1'b0; in_valid1 = 1'b0; in_pc = 32'd0;
        in_inst0 = 32'd0; in_inst1 = 32'd0; in_tlb_refill = 1'b0; in_tlb_invalid = 1'b0;
        pop_cnt = 2'd0;
    endtask

    task automatic applyStimulus(input logic v0, input logic v1, input logic [31:0] pc,
                                 input logic refill, input logic inval,
                                 input logic [1:0] pop, input logic fl);
        #1;
        in_valid0 = v0; in_valid1 = v1; in_pc = pc;
        in_inst0 = pc ^ 32'h1234_5678; in_inst1 = (pc + 32'd4) ^ 32'h1234_5678;
        in_tlb_refill = refill; in_tlb_invalid = inval; pop_cnt = pop; flush = fl;
        @(posedge clk);
        #1;
        setIdle();
    endtask

    logic [31:0] nextPc, headPc;

    initial begin
        rst = 1'b1;
        setIdle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset.count", 32'(count), 32'd0);
        checkOutput("reset.valid0", 32'(out_valid0), 32'd0);
        checkOutput("reset.full", 32'(full), 32'd0);

        applyStimulus(1, 1, 32'hBFC0_0000, 0, 0, 2'd0, 0);
        @(negedge clk);
        checkOutput("first.count", 32'(count), 32'd2);
        checkOutput("first.pc0", out_pc0, 32'hBFC0_0000);
        checkOutput("first.pc1", out_pc1, 32'hBFC0_0004);
        applyStimulus(0, 0, 32'd0, 0, 0, 2'd2, 0);

        applyStimulus(1, 1, 32'h0040_0000, 1, 0, 2'd0, 0);
        @(negedge clk);
        checkOutput("refill.count", 32'(count), 32'd1);
        checkOutput("refill.flag0", 32'(out_tlb_refill0), 32'd1);
        checkOutput("refill.valid1", 32'(out_valid1), 32'd0);
        applyStimulus(1, 1, 32'h0050_0000, 0, 1, 2'd1, 0);
        @(negedge clk);
        checkOutput("invalid.count", 32'(count), 32'd1);
        checkOutput("invalid.pc0", out_pc0, 32'h0050_0000);
        checkOutput("invalid.flag0", 32'(out_tlb_invalid0), 32'd1);
        applyStimulus(0, 0, 32'd0, 0, 0, 2'd1, 0);

        for (int i = 0; i < 7; i++)
            applyStimulus(1, 1, 32'h1000_0000 + 32'(i * 8), 0, 0, 2'd0, 0);
        @(negedge clk);
        checkOutput("fill14.full", 32'(full), 32'd0);
        applyStimulus(1, 0, 32'h1000_0038, 0, 0, 2'd0, 0);
        @(negedge clk);
        checkOutput("fill15.count", 32'(count), 32'd15);
        checkOutput("fill15.full", 32'(full), 32'd1);
        applyStimulus(1, 1, 32'h2000_0000, 0, 0, 2'd0, 0);
        @(negedge clk);
        checkOutput("fullpush.count", 32'(count), 32'd15);
        checkOutput("fullpush.pc0", out_pc0, 32'h1000_0000);
        repeat (3) applyStimulus(0, 0, 32'd0, 0, 0, 2'd2, 0);
        @(negedge clk);
        checkOutput("drain9.count", 32'(count), 32'd9);

        applyStimulus(1, 1, 32'h3000_0000, 0, 0, 2'd2, 1);
        @(negedge clk);
        checkOutput("flush.count", 32'(count), 32'd0);
        checkOutput("flush.valid0", 32'(out_valid0), 32'd0);
        checkOutput("flush.full", 32'(full), 32'd0);

        // Steady stream at count 3 walks head and tail across the 15->0 wrap.
        applyStimulus(1, 1, 32'h4000_0000, 0, 0, 2'd0, 0);
        applyStimulus(1, 0, 32'h4000_0008, 0, 0, 2'd0, 0);
        headPc = 32'h4000_0000;
        nextPc = 32'h4000_000C;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 1, nextPc, 0, 0, 2'd2, 0);
            nextPc += 32'd8;
            headPc += 32'd8;
            @(negedge clk);
            checkOutput("steady.count", 32'(count), 32'd3);
            checkOutput("steady.pc0", out_pc0, headPc);
            checkOutput("steady.pc1", out_pc1, headPc + 32'd4);
        end

        #1;
        rst = 1'b1; in_valid0 = 1'b1; in_valid1 = 1'b1; in_pc = 32'h5000_0000; pop_cnt = 2'd2;
        @(posedge clk);
        #1 rst = 1'b0;
        setIdle();
        @(negedge clk);
        checkOutput("midreset.count", 32'(count), 32'd0);
        checkOutput("midreset.valid0", 32'(out_valid0), 32'd0);

        #1;
        in_valid0 = 1'b1; in_pc = 32'h8000_0000; in_inst0 = 32'h8000_0000 ^ 32'h1234_5678;
`ifdef INST_FETCH_BUFFER_BYPASS_EN
        pop_cnt = 2'd1;
        #1;
        checkOutput("bypass.valid0", 32'(out_valid0), 32'd1);
        checkOutput("bypass.pc0", out_pc0, 32'h8000_0000);
        @(posedge clk);
        #1 setIdle();
        @(negedge clk);
        checkOutput("bypass.countAfter", 32'(count), 32'd0);
`else
        #1;
        checkOutput("nobypass.valid0", 32'(out_valid0), 32'd0);
        @(posedge clk);
        #1 setIdle();
        @(negedge clk);
        checkOutput("nobypass.countAfter", 32'(count), 32'd1);
        checkOutput("nobypass.pc0", out_pc0, 32'h8000_0000);
        applyStimulus(0, 0, 32'd0, 0, 0, 2'd1, 0);
`endif

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
